// File: rtl/sr_chain_pkg.sv
// Shared definitions for the shift-register chain loader: register map,
// CTRL/STATUS bit positions, FSM encoding and the chain word-count helper.
package sr_chain_pkg;

    // Register indices are the byte offsets divided by four.
    // The offsets are CTRL 0x0, STATUS 0x4, TXDATA 0x8, RXDATA 0xC and CRC 0x10.
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_TXDATA = 3'd2;
    localparam logic [2:0] REG_RXDATA = 3'd3;
    localparam logic [2:0] REG_CRC    = 3'd4;

    // CTRL bit positions
    localparam int CTRL_START    = 0;
    localparam int CTRL_ABORT    = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_LOOPBACK = 3;

    // STATUS bit positions
    localparam int STAT_BUSY       = 0;
    localparam int STAT_DONE       = 1;
    localparam int STAT_TX_OVF     = 2;
    localparam int STAT_RX_OVF     = 3;
    localparam int STAT_START_ERR  = 4;
    localparam int STAT_TX_LVL_LSB = 8;
    localparam int STAT_RX_LVL_LSB = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SHIFT  = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } sr_state_t;

    // Number of 32-bit words needed to hold a chain of chain_len bits.
    function automatic int nw(input int chain_len);
        return (chain_len + 31) / 32;
    endfunction

endpackage

// File: rtl/sr_word_fifo.sv
// Synchronous word FIFO with first-word fall-through read data, a
// synchronous flush and a level output one bit wider than the pointers.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sr_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_MAX = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_MAX);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array: written on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sr_chain_loader.sv
// Wishbone front end for the configuration shift-register chain.
// Words written to TXDATA are shifted LSB-first onto sr_sin; bits returning on
// sr_sout (or sr_sin in loopback) are packed into words for RXDATA readback,
// then sr_update latches the chain.
// Optional build macro SR_CHAIN_CRC_EN adds a CRC-16-CCITT over sr_sout readable
// at offset 0x10; without it that offset reads 0.
module sr_chain_loader
    import sr_chain_pkg::*;
#(
    parameter int          CHAIN_LEN  = 164,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_addr,
    input  logic        valid,
    input  logic        wen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sr_sin,
    output logic        sr_shift_en,
    input  logic        sr_sout,
    output logic        sr_update,
    output logic        irq
);

    localparam int NW  = nw(CHAIN_LEN);
    localparam int LW  = $clog2(FIFO_DEPTH) + 1;
    localparam int BCW = $clog2(CHAIN_LEN + 1);
    localparam logic [LW-1:0]  NW_L     = LW'(NW);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(CHAIN_LEN - 1);
    localparam logic [BCW-1:0] BC_ONE   = BCW'(1);

    // Bus decode and command capture
    logic        addr_hit;
    logic [2:0]  idx;
    logic        accept;
    logic [31:0] rd_val;
    logic        cmd_wr;
    logic [2:0]  cmd_idx;
    logic [31:0] cmd_data;
    logic        ctrl_wr;
    logic        stat_wr;
    logic        start_req;
    logic        abort_req;
    logic        tx_push;
    logic        rx_pop;

    // Control / status state
    sr_state_t   state;
    sr_state_t   state_n;
    logic        busy;
    logic        done;
    logic        tx_ovf;
    logic        rx_ovf;
    logic        start_err;
    logic        irq_en;
    logic        loopback;
    logic        start_ok;
    logic        start_bad;
    logic        flush;
    logic        tx_pop;
    logic        rx_push;
    logic        shift_en;
    logic        update;

    // Shift datapath
    logic [31:0]    txsr;
    logic [31:0]    rxsr;
    logic [31:0]    rx_word;
    logic [BCW-1:0] bit_cnt;
    logic [4:0]     word_pos;
    logic           word_end;
    logic           last_bit;
    logic           sample;

    // FIFO interfaces
    logic [31:0]   tx_rdata;
    logic          tx_full;
    logic          tx_empty;
    logic [LW-1:0] tx_level;
    logic [31:0]   rx_rdata;
    logic          rx_full;
    logic          rx_empty;
    logic [LW-1:0] rx_level;
    logic [15:0]   crc_val;

    // The 16-byte window holds CTRL..RXDATA; the CRC word at +0x10 is decoded
    // as a single extra address so it is reachable in both builds.
    assign addr_hit = (wb_addr[31:4] == BASE_ADDR[31:4]) || (wb_addr == BASE_ADDR + 32'h10);
    assign idx      = (wb_addr == BASE_ADDR + 32'h10) ? REG_CRC : {1'b0, wb_addr[3:2]};
    assign accept   = valid && addr_hit && !ready;
    assign rx_pop   = accept && !wen && (idx == REG_RXDATA);

    // Writes take effect in the ack cycle, from the captured command.
    assign ctrl_wr   = cmd_wr && (cmd_idx == REG_CTRL);
    assign stat_wr   = cmd_wr && (cmd_idx == REG_STATUS);
    assign tx_push   = cmd_wr && (cmd_idx == REG_TXDATA);
    assign start_req = ctrl_wr && cmd_data[CTRL_START];
    assign abort_req = ctrl_wr && cmd_data[CTRL_ABORT];

    assign busy = (state == S_LOAD) || (state == S_SHIFT) || (state == S_UPDATE);

    // Read data mux, evaluated in the accept cycle and registered for the ack.
    always_comb begin
        rd_val = '0;
        case (idx)
            REG_STATUS: rd_val = {12'd0, 4'(rx_level), 4'd0, 4'(tx_level), 3'd0,
                                  start_err, rx_ovf, tx_ovf, done, busy};
            REG_RXDATA: rd_val = rx_empty ? 32'd0 : rx_rdata;
            REG_CRC:    rd_val = {16'd0, crc_val};
            default:    rd_val = '0;
        endcase
    end

    // Bus handshake: one-cycle ack, read data only while acked, write capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready    <= 1'b0;
            rdata    <= '0;
            cmd_wr   <= 1'b0;
            cmd_idx  <= REG_CTRL;
            cmd_data <= '0;
        end else begin
            ready    <= accept;
            rdata    <= (accept && !wen) ? rd_val : 32'd0;
            cmd_wr   <= accept && wen;
            cmd_idx  <= idx;
            cmd_data <= wdata;
        end
    end

    assign word_end = (word_pos == 5'd31);
    assign last_bit = (bit_cnt == LAST_BIT);
    assign start_bad = start_req && (busy || (tx_level < NW_L));

    // FSM next state and per-cycle strobes.
    always_comb begin
        state_n  = state;
        start_ok = 1'b0;
        flush    = 1'b0;
        tx_pop   = 1'b0;
        rx_push  = 1'b0;
        shift_en = 1'b0;
        update   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                state_n = S_IDLE;
                if (start_req && (tx_level >= NW_L)) begin
                    state_n  = S_LOAD;
                    start_ok = 1'b1;
                end
            end
            S_LOAD: begin
                tx_pop  = 1'b1;
                state_n = S_SHIFT;
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                tx_pop   = word_end && !last_bit;
                rx_push  = word_end || last_bit;
                if (last_bit) begin
                    state_n = S_UPDATE;
                end
            end
            S_UPDATE: begin
                update  = 1'b1;
                state_n = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase
        // Abort overrides whatever the busy state was about to do.
        if (abort_req && busy) begin
            state_n = S_IDLE;
            flush   = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    assign sample  = loopback ? sr_sin : sr_sout;
    assign rx_word = rxsr | (32'(sample) << word_pos);

    // Serial datapath: TX shifter, RX assembler and bit counters. A fresh RX
    // word starts from zero so the bits beyond the chain end read back as 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txsr     <= '0;
            rxsr     <= '0;
            bit_cnt  <= '0;
            word_pos <= '0;
        end else if (state == S_LOAD) begin
            txsr     <= tx_empty ? 32'd0 : tx_rdata;
            rxsr     <= '0;
            bit_cnt  <= '0;
            word_pos <= '0;
        end else if (shift_en) begin
            txsr     <= tx_pop ? tx_rdata : (txsr >> 1);
            rxsr     <= rx_push ? 32'd0 : rx_word;
            bit_cnt  <= bit_cnt + BC_ONE;
            word_pos <= word_pos + 5'd1;
        end
    end

    // Sticky status flags and CTRL configuration bits; a new event wins over W1C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done      <= 1'b0;
            tx_ovf    <= 1'b0;
            rx_ovf    <= 1'b0;
            start_err <= 1'b0;
            irq_en    <= 1'b0;
            loopback  <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_en   <= cmd_data[CTRL_IRQ_EN];
                loopback <= cmd_data[CTRL_LOOPBACK];
            end
            if (stat_wr && cmd_data[STAT_DONE])      done      <= 1'b0;
            if (stat_wr && cmd_data[STAT_TX_OVF])    tx_ovf    <= 1'b0;
            if (stat_wr && cmd_data[STAT_RX_OVF])    rx_ovf    <= 1'b0;
            if (stat_wr && cmd_data[STAT_START_ERR]) start_err <= 1'b0;
            if (start_ok)                                  done      <= 1'b0;
            if ((state == S_UPDATE) && (state_n == S_DONE)) done      <= 1'b1;
            if (tx_push && tx_full && !tx_pop)             tx_ovf    <= 1'b1;
            if (rx_push && rx_full && !rx_pop && !flush)   rx_ovf    <= 1'b1;
            if (start_bad)                                 start_err <= 1'b1;
        end
    end

`ifdef SR_CHAIN_CRC_EN
    logic [15:0] crc;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // CRC-16-CCITT over the returning chain bits, restarted at every load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc <= '0;
        end else if (state == S_LOAD) begin
            crc <= 16'hFFFF;
        end else if (shift_en) begin
            crc <= crc16_step(crc, sr_sout);
        end
    end

    assign crc_val = crc;
`else
    assign crc_val = 16'h0000;
`endif

    assign sr_shift_en = shift_en;
    assign sr_sin      = shift_en & txsr[0];
    assign sr_update   = update;
    assign irq         = done & irq_en;

    sr_word_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (tx_push),
        .wdata (cmd_data),
        .pop   (tx_pop),
        .rdata (tx_rdata),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    sr_word_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (rx_push),
        .wdata (rx_word),
        .pop   (rx_pop),
        .rdata (rx_rdata),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

endmodule
